branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 105 ++++++++++
 tb/tb_branch_predictor.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters,
// resolve-stage update port, mispredict detection and saturating perf counters.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        pred_hit,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  input  logic        bp_clear,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [31:0] perf_br_q, perf_mis_q;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;

  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Lookup reads the registered table only, so a same-cycle update is not visible.
  always_comb begin
    pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit && ctr_q[lk_idx][1];
    pred_target = pred_taken ? target_q[lk_idx] : if_pc + 32'd4;
  end

  always_comb begin
    up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    mispredict  = upd_valid && ((upd_pred_taken != upd_taken) ||
                                (upd_taken && (upd_pred_target != upd_target)));
    redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (bp_clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          ctr_q[up_idx]    <= (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'b01;
          target_q[up_idx] <= upd_target;
        end else begin
          ctr_q[up_idx]    <= (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        ctr_q[up_idx]    <= 2'b10;
      end
    end
  end

  // Perf counters count even when bp_clear drops the table update.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else begin
      if (upd_valid && (perf_br_q != 32'hFFFF_FFFF)) begin
        perf_br_q <= perf_br_q + 32'd1;
      end
      if (mispredict && (perf_mis_q != 32'hFFFF_FFFF)) begin
        perf_mis_q <= perf_mis_q + 32'd1;
      end
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: cold lookup, training, saturation,
// aliasing, clear-vs-update, perf saturation and asynchronous reset.
module tb_branch_predictor;

  logic        cpu_clk;
  logic        cpu_rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_hit;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        bp_clear;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  int checks = 0;
  int errors = 0;

  branch_predictor #(
    .ENTRIES(16),
    .TAG_W  (8)
  ) dut (
    .cpu_clk         (cpu_clk),
    .cpu_rst         (cpu_rst),
    .if_pc           (if_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .pred_hit        (pred_hit),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .bp_clear        (bp_clear),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .perf_branches   (perf_branches),
    .perf_mispredicts(perf_mispredicts)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  // Drive an update for the coming edge and let combinational outputs settle.
  task automatic drive_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
    #1;
  endtask

  task automatic end_upd();
    upd_valid = 1'b0;
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  initial begin
    cpu_rst = 1'b1;
    if_pc = 32'h100;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_taken = 1'b0;
    upd_target = '0;
    upd_pred_taken = 1'b0;
    upd_pred_target = '0;
    bp_clear = 1'b0;

    // Reset state and cold lookup
    #2;
    chk("rst_hit", pred_hit, 0);
    chk("rst_taken", pred_taken, 0);
    chk("rst_target", pred_target, 32'h104);
    chk("rst_perf_br", perf_branches, 0);
    chk("rst_perf_mis", perf_mispredicts, 0);
    chk("rst_ctr", dut.ctr_q[0], 2'b01);
    tick();
    cpu_rst = 1'b0;
    #1;
    chk("cold_hit", pred_hit, 0);
    chk("cold_target", pred_target, 32'h104);

    // Allocate 0x100 -> 0x80; same-cycle lookup still sees the old (empty) entry
    drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    chk("alloc_mis", mispredict, 1);
    chk("alloc_redir", redirect_pc, 32'h80);
    chk("alloc_nobypass", pred_hit, 0);
    tick();
    end_upd();
    chk("train_hit", pred_hit, 1);
    chk("train_taken", pred_taken, 1);
    chk("train_target", pred_target, 32'h80);
    chk("train_ctr", dut.ctr_q[0], 2'b10);
    chk("train_br", perf_branches, 1);
    chk("train_mis", perf_mispredicts, 1);

    // Two correctly predicted taken updates: 10 -> 11 -> 11
    drive_upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    chk("correct_nomis", mispredict, 0);
    tick();
    chk("sat_up1", dut.ctr_q[0], 2'b11);
    tick();
    end_upd();
    chk("sat_up2", dut.ctr_q[0], 2'b11);

    // Taken with a new target: direction right, target wrong
    drive_upd(32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
    chk("tgt_mis", mispredict, 1);
    chk("tgt_redir", redirect_pc, 32'h90);
    tick();
    end_upd();
    chk("tgt_new", pred_target, 32'h90);

    // Not-taken once: still predicts taken
    drive_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h90);
    chk("nt1_mis", mispredict, 1);
    chk("nt1_redir", redirect_pc, 32'h104);
    tick();
    end_upd();
    chk("nt1_taken", pred_taken, 1);
    chk("nt1_ctr", dut.ctr_q[0], 2'b10);

    // Not-taken twice: predicts not-taken, falls through
    drive_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h90);
    tick();
    end_upd();
    chk("nt2_hit", pred_hit, 1);
    chk("nt2_taken", pred_taken, 0);
    chk("nt2_target", pred_target, 32'h104);
    chk("nt2_ctr", dut.ctr_q[0], 2'b01);

    // Drive down to 00 and check low saturation
    drive_upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
    chk("nt3_nomis", mispredict, 0);
    tick();
    chk("sat_dn1", dut.ctr_q[0], 2'b00);
    tick();
    end_upd();
    chk("sat_dn2", dut.ctr_q[0], 2'b00);
    chk("perf_br8", perf_branches, 8);
    chk("perf_mis4", perf_mispredicts, 4);

    // Not-taken miss at 0x200 (same index, other tag) leaves table intact
    drive_upd(32'h200, 1'b0, 32'h0, 1'b0, 32'h204);
    tick();
    end_upd();
    chk("ntmiss_hit", pred_hit, 1);
    chk("ntmiss_tag", dut.tag_q[0], 8'h04);

    // Alias: taken at 0x140 replaces 0x100
    drive_upd(32'h140, 1'b1, 32'h300, 1'b0, 32'h144);
    tick();
    end_upd();
    chk("alias_old_miss", pred_hit, 0);
    look(32'h140);
    chk("alias_new_hit", pred_hit, 1);
    chk("alias_new_tgt", pred_target, 32'h300);

    // Idle cycle with garbage update fields changes nothing
    upd_pc = 32'h140;
    upd_taken = 1'b1;
    upd_target = 32'h999;
    upd_pred_taken = 1'b0;
    #1;
    chk("idle_nomis", mispredict, 0);
    tick();
    chk("idle_tgt", pred_target, 32'h300);
    chk("idle_br", perf_branches, 10);
    chk("idle_mis", perf_mispredicts, 5);

    // Second entry at index 1
    drive_upd(32'h104, 1'b1, 32'h400, 1'b0, 32'h108);
    tick();
    end_upd();
    look(32'h104);
    chk("idx1_hit", pred_hit, 1);

    // bp_clear with a simultaneous taken update: update dropped, perf counted
    bp_clear = 1'b1;
    drive_upd(32'h108, 1'b1, 32'h500, 1'b0, 32'h10C);
    tick();
    bp_clear = 1'b0;
    end_upd();
    chk("clr_idx1", pred_hit, 0);
    look(32'h140);
    chk("clr_idx0", pred_hit, 0);
    chk("clr_idx0_tgt", pred_target, 32'h144);
    look(32'h108);
    chk("clr_dropped", pred_hit, 0);
    chk("clr_br", perf_branches, 12);
    chk("clr_mis", perf_mispredicts, 7);

    // Perf mispredict saturation
    force dut.perf_mis_q = 32'hFFFF_FFFE;
    #1;
    release dut.perf_mis_q;
    #1;
    chk("psat_pre", perf_mispredicts, 32'hFFFF_FFFE);
    drive_upd(32'h10C, 1'b1, 32'h600, 1'b0, 32'h110);
    tick();
    chk("psat_max", perf_mispredicts, 32'hFFFF_FFFF);
    tick();
    end_upd();
    chk("psat_hold", perf_mispredicts, 32'hFFFF_FFFF);
    chk("psat_br", perf_branches, 14);

    // Asynchronous reset mid-update wins immediately
    look(32'h10C);
    chk("pre_rst_hit", pred_hit, 1);
    drive_upd(32'h100, 1'b1, 32'h700, 1'b0, 32'h104);
    cpu_rst = 1'b1;
    #1;
    chk("arst_hit", pred_hit, 0);
    chk("arst_br", perf_branches, 0);
    chk("arst_mis", perf_mispredicts, 0);
    tick();
    cpu_rst = 1'b0;
    end_upd();
    look(32'h100);
    chk("arst_no_partial", pred_hit, 0);
    chk("arst_tgt", pred_target, 32'h104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
